// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - buffered 8N1 UART transmitter with byte FIFO
//
// Optional feature macro: UART_TX_PARITY_EN (adds an even-parity bit after bit 7)
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-high reset
//   wr_en        one-cycle write strobe, accepted when fifo_full=0
//   wr_data      byte to enqueue
//   clr_overflow clears the sticky overflow flag
//   fifo_full    count == FIFO_DEPTH (registered)
//   fifo_empty   count == 0 (registered)
//   fifo_count   number of queued bytes
//   overflow     sticky: a write was dropped because the FIFO was full
//   tx_busy      high whenever the FSM is not in IDLE
//   tx_pin       serial line, idle high
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  input  logic                          clr_overflow,
  output logic                          fifo_full,
  output logic                          fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          tx_busy,
  output logic                          tx_pin
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int PTR_W        = $clog2(FIFO_DEPTH);
  localparam int CW           = PTR_W + 1;

`ifdef UART_TX_PARITY_EN
  // Index 8 is the parity slot that follows data bit 7.
  localparam int               IDX_W    = 4;
  localparam logic [IDX_W-1:0] LAST_BIT = 4'd8;
`else
  localparam int               IDX_W    = 3;
  localparam logic [IDX_W-1:0] LAST_BIT = 3'd7;
`endif

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state, state_next;
  logic [7:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]      count_next;
  logic [CNT_W-1:0]   baud_cnt;
  logic [IDX_W-1:0]   bit_idx;
  logic [7:0]         shift_reg;
  logic               wr_accept;
  logic               pop;
  logic               bit_done;
  logic               data_bit;

  // Fullness is judged on the registered flag, so a write arriving while
  // full is dropped even if the FSM frees a slot on the same edge.
  assign wr_accept = wr_en && !fifo_full;
  assign pop       = (state == IDLE) && !fifo_empty;
  assign bit_done  = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));

  always_comb begin
    count_next = fifo_count;
    case ({wr_accept, pop})
      2'b10:   count_next = fifo_count + 1'b1;
      2'b01:   count_next = fifo_count - 1'b1;
      default: count_next = fifo_count;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      fifo_full  <= 1'b0;
      fifo_empty <= 1'b1;
      overflow   <= 1'b0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)       rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= count_next;
      fifo_full  <= (count_next == CW'(FIFO_DEPTH));
      fifo_empty <= (count_next == '0);
      // A drop wins over a simultaneous clear.
      if (wr_en && fifo_full) overflow <= 1'b1;
      else if (clr_overflow)  overflow <= 1'b0;
    end
  end

  // Storage needs no reset: emptying the pointers discards queued bytes.
  // A pop reads rd_ptr while a write lands on wr_ptr, which only coincide
  // when the FIFO is empty (no pop) or full (no write).
  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_ptr] <= wr_data;
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // FSM next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!fifo_empty) state_next = START;
      START:   if (bit_done) state_next = DATA;
      DATA:    if (bit_done && (bit_idx == LAST_BIT)) state_next = STOP;
      STOP:    if (bit_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Baud counter, bit index and shift register. Both counters are held at
  // zero in IDLE so every frame starts from a clean bit boundary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
    end else if (state == IDLE) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      if (pop) shift_reg <= mem[rd_ptr];
    end else begin
      baud_cnt <= bit_done ? '0 : baud_cnt + 1'b1;
      if ((state == DATA) && bit_done) bit_idx <= bit_idx + 1'b1;
    end
  end

`ifdef UART_TX_PARITY_EN
  assign data_bit = bit_idx[3] ? (^shift_reg) : shift_reg[bit_idx[2:0]];
`else
  assign data_bit = shift_reg[bit_idx];
`endif

  // FSM outputs
  always_comb begin
    tx_busy = (state != IDLE);
    tx_pin  = 1'b1;
    case (state)
      START:   tx_pin = 1'b0;
      DATA:    tx_pin = data_bit;
      default: tx_pin = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;

  localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYC = FRAME_BITS * CPB;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       frame_ok;
    int         start;
  } frame_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       clr_overflow;
  logic       fifo_full;
  logic       fifo_empty;
  logic [2:0] fifo_count;
  logic       overflow;
  logic       tx_busy;
  logic       tx_pin;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         max_cnt = 0;
  bit         mon_en = 1'b0;
  logic [7:0] exp_q[$];
  frame_t     rx_q[$];
  frame_t     mon_f;
  bit         mon_ok;

  uart_tx_fifo #(
    .CLK_FREQ   (1600000),
    .BAUD_RATE  (100000),
    .FIFO_DEPTH (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .clr_overflow (clr_overflow),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .fifo_count   (fifo_count),
    .overflow     (overflow),
    .tx_busy      (tx_busy),
    .tx_pin       (tx_pin)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset && int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
  end

  // Line decoder: samples each bit in the middle of its 16-cycle cell.
  always begin
    @(negedge clk);
    if (mon_en && !reset && tx_pin === 1'b0) begin
      mon_f.start = cyc;
      mon_ok = 1'b1;
      repeat (7) @(negedge clk);
      if (tx_pin !== 1'b0) mon_ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        mon_f.data[i] = tx_pin;
      end
`ifdef UART_TX_PARITY_EN
      repeat (CPB) @(negedge clk);
      mon_f.par = tx_pin;
`else
      mon_f.par = 1'b0;
`endif
      repeat (CPB) @(negedge clk);
      if (tx_pin !== 1'b1) mon_ok = 1'b0;
      mon_f.frame_ok = mon_ok;
      rx_q.push_back(mon_f);
    end
  end

  task automatic wait_rx(input int n, input int budget, output bit ok);
    while (rx_q.size() < n && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    ok = (rx_q.size() >= n);
  endtask

  task automatic wait_idle(output bit ok);
    int budget = 3000;
    while (!(tx_busy === 1'b0 && fifo_empty === 1'b1) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    ok = (tx_busy === 1'b0 && fifo_empty === 1'b1);
  endtask

  task automatic write_byte(input logic [7:0] d, input bit accept);
    wr_en   = 1'b1;
    wr_data = d;
    if (accept) exp_q.push_back(d);
    @(negedge clk);
  endtask

  task automatic test_reset();
    int zeros = 0;
    reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00; clr_overflow = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx_pin, tx_busy, fifo_empty, fifo_full, fifo_count, overflow} !== 8'b1010_0000) begin
      errors++;
      $display("FAIL reset_state: got %b want 10100000",
               {tx_pin, tx_busy, fifo_empty, fifo_full, fifo_count, overflow});
    end
    reset = 1'b0;
    @(negedge clk);
    write_byte(8'h5A, 1'b0);
    write_byte(8'h6B, 1'b0);
    wr_en = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (tx_pin !== 1'b0) begin
      errors++;
      $display("FAIL reset_setup_start: tx_pin got %b want 0", tx_pin);
    end
    #3 reset = 1'b1;
    #1;
    checks++;
    if (tx_pin !== 1'b1) begin errors++; $display("FAIL reset_mid_tx_pin: got %b want 1", tx_pin); end
    checks++;
    if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_mid_busy: got %b want 0", tx_busy); end
    checks++;
    if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_mid_count: got %0d want 0", fifo_count); end
    @(negedge clk);
    reset = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (tx_pin !== 1'b1 || tx_busy !== 1'b0) zeros++;
    end
    checks++;
    if (zeros != 0) begin errors++; $display("FAIL reset_quiet: active cycles %0d want 0", zeros); end
    mon_en = 1'b1;
  endtask

  task automatic test_single();
    logic [7:0] d = 8'hA5;
    int bad = 0;
    int lv;
    logic want;
    bit ok;
    frame_t f;
    logic [7:0] e;
    write_byte(d, 1'b1);
    wr_en = 1'b0;
    checks++;
    if (tx_pin !== 1'b1 || tx_busy !== 1'b0 || fifo_empty !== 1'b0) begin
      errors++;
      $display("FAIL single_edge_n: pin/busy/empty got %b%b%b want 100", tx_pin, tx_busy, fifo_empty);
    end
    for (int k = 0; k < FRAME_CYC; k++) begin
      @(negedge clk);
      lv = k / CPB;
      if (lv == 0) want = 1'b0;
      else if (lv <= 8) want = d[lv-1];
      else if (FRAME_BITS == 11 && lv == 9) want = ^d;
      else want = 1'b1;
      if (tx_pin !== want || tx_busy !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL single_waveform: bad cycles %0d want 0", bad); end
    @(negedge clk);
    checks++;
    if (tx_busy !== 1'b0 || tx_pin !== 1'b1 || fifo_empty !== 1'b1) begin
      errors++;
      $display("FAIL single_end: busy/pin/empty got %b%b%b want 011", tx_busy, tx_pin, fifo_empty);
    end
    wait_rx(1, 100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_rx_timeout: frames %0d want 1", rx_q.size()); end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      f = rx_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (f.data !== e || !f.frame_ok) begin
        errors++;
        $display("FAIL single_data: got %h ok=%0b want %h", f.data, f.frame_ok, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    frame_t f;
    logic [7:0] e;
    int prev = -1;
    write_byte(8'h01, 1'b1);
    write_byte(8'h02, 1'b1);
    write_byte(8'h03, 1'b1);
    wr_en = 1'b0;
    wait_rx(3, 1000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_rx_timeout: frames %0d want 3", rx_q.size()); end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      f = rx_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (f.data !== e || !f.frame_ok) begin
        errors++;
        $display("FAIL b2b_data: got %h ok=%0b want %h", f.data, f.frame_ok, e);
      end
      if (prev >= 0) begin
        checks++;
        if (f.start - prev != FRAME_CYC + 1) begin
          errors++;
          $display("FAIL b2b_period: got %0d want %0d", f.start - prev, FRAME_CYC + 1);
        end
      end
      prev = f.start;
    end
  endtask

  task automatic test_overflow();
    bit ok;
    frame_t f;
    logic [7:0] e;
    max_cnt = 0;
    write_byte(8'h11, 1'b1);
    write_byte(8'h22, 1'b1);
    write_byte(8'h33, 1'b1);
    write_byte(8'h44, 1'b1);
    write_byte(8'h55, 1'b1);
    checks++;
    if (fifo_full !== 1'b1 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_full: full/ovf got %b%b want 10", fifo_full, overflow);
    end
    write_byte(8'hFF, 1'b0);
    wr_en = 1'b0;
    checks++;
    if (overflow !== 1'b1 || fifo_count !== 3'd4) begin
      errors++;
      $display("FAIL ovf_set: ovf=%b count=%0d want 1 and 4", overflow, fifo_count);
    end
    clr_overflow = 1'b1;
    write_byte(8'hEE, 1'b0);
    wr_en = 1'b0;
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_clr_vs_drop: got %b want 1", overflow); end
    @(negedge clk);
    clr_overflow = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", overflow); end
    wait_rx(5, 1500, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL ovf_rx_timeout: frames %0d want 5", rx_q.size()); end
    wait_idle(ok);
    repeat (40) @(negedge clk);
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      f = rx_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (f.data !== e || !f.frame_ok) begin
        errors++;
        $display("FAIL ovf_data: got %h ok=%0b want %h", f.data, f.frame_ok, e);
      end
    end
    checks++;
    if (rx_q.size() != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL ovf_extra: rx left %0d exp left %0d want 0 0", rx_q.size(), exp_q.size());
    end
    checks++;
    if (max_cnt > 4) begin errors++; $display("FAIL ovf_max_count: got %0d want <=4", max_cnt); end
  endtask

  task automatic test_simul();
    bit ok;
    frame_t f;
    logic [7:0] e;
    write_byte(8'h31, 1'b1);
    write_byte(8'h32, 1'b1);
    write_byte(8'h33, 1'b1);
    wr_en = 1'b0;
    repeat (FRAME_CYC - 1) @(negedge clk);
    checks++;
    if (tx_busy !== 1'b0 || fifo_count !== 3'd2) begin
      errors++;
      $display("FAIL simul_setup: busy=%b count=%0d want 0 and 2", tx_busy, fifo_count);
    end
    write_byte(8'h34, 1'b1);
    wr_en = 1'b0;
    checks++;
    if (fifo_count !== 3'd2 || tx_busy !== 1'b1) begin
      errors++;
      $display("FAIL simul_count: count=%0d busy=%b want 2 and 1", fifo_count, tx_busy);
    end
    wait_rx(4, 1500, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL simul_rx_timeout: frames %0d want 4", rx_q.size()); end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      f = rx_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (f.data !== e || !f.frame_ok) begin
        errors++;
        $display("FAIL simul_data: got %h ok=%0b want %h", f.data, f.frame_ok, e);
      end
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    bit ok;
    frame_t f;
    int busy_len;
    logic [7:0] vals [2];
    vals[0] = 8'h07;
    vals[1] = 8'h03;
    for (int v = 0; v < 2; v++) begin
      wait_idle(ok);
      write_byte(vals[v], 1'b1);
      wr_en = 1'b0;
      busy_len = 0;
      @(negedge clk);
      while (tx_busy === 1'b1 && busy_len < 400) begin
        busy_len++;
        @(negedge clk);
      end
      checks++;
      if (busy_len != 176) begin errors++; $display("FAIL parity_len: got %0d want 176", busy_len); end
      wait_rx(1, 100, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL parity_rx_timeout: frames %0d want 1", rx_q.size());
      end else begin
        f = rx_q.pop_front();
        void'(exp_q.pop_front());
        checks++;
        if (f.par !== ^vals[v] || f.data !== vals[v]) begin
          errors++;
          $display("FAIL parity_bit: data %h par %b want %h par %b", f.data, f.par, vals[v], ^vals[v]);
        end
      end
    end
  endtask
`endif

  initial begin
    bit ok;
    test_reset();
    test_single();
    wait_idle(ok);
    test_back_to_back();
    wait_idle(ok);
    test_overflow();
    wait_idle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL idle_timeout: busy=%b empty=%b want 0 1", tx_busy, fifo_empty); end
    test_simul();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Buffered, memory-mapped UART transmitter peripheral. It is the transmit-side counterpart to the core's byte receive path.
- The core writes bytes through the memory controller's write strobe. The block queues them in a FIFO and serializes them onto tx_pin as 8N1 frames.
- There is no per-byte start handshake: the core only polls fifo_full and tx_busy.

Parameters:
- CLK_FREQ, 50000000: input clock frequency in Hz.
- BAUD_RATE, 115200: line rate in bits/s. CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer divide), and must be ≥ 2.
- FIFO_DEPTH, 8: number of byte entries. Must be a power of 2 and ≥ 2.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-high reset.
- wr_en, input, 1: one-cycle write strobe from the memory controller.
- wr_data, input, 8: byte to enqueue.
- clr_overflow, input, 1: clears the overflow flag.
- fifo_full, output, 1: count == FIFO_DEPTH.
- fifo_empty, output, 1: count == 0.
- fifo_count, output, $clog2(FIFO_DEPTH)+1: number of queued bytes.
- overflow, output, 1: sticky flag; a write was dropped.
- tx_busy, output, 1: high when the FSM is not in IDLE.
- tx_pin, output, 1: serial line, idle high.

Behaviour:
- Reset (async, takes effect immediately):
  - tx_pin=1, tx_busy=0, fifo_empty=1, fifo_full=0, fifo_count=0, overflow=0.
  - Read and write pointers = 0; FSM = IDLE; baud counter and bit index = 0.
- Reset mid-frame aborts the frame: tx_pin returns to 1 at once and queued bytes are discarded.
- FIFO:
  - Write is accepted on a rising edge with wr_en=1 and fifo_full=0.
  - A write while fifo_full=1 is dropped and sets overflow=1. This holds even if a pop occurs in the same cycle (fullness is judged before the edge).
  - overflow stays set until clr_overflow=1. If clr_overflow and a dropped write coincide, the flag stays set.
  - Pointers wrap modulo FIFO_DEPTH.
  - Simultaneous accepted write and pop leave fifo_count unchanged.
  - Flags and count are registered and update on the same edge as the pointer change.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE:
    - tx_pin=1.
    - If fifo_empty=0: pop the head byte into the shift register, clear the baud counter and go to START.
    - A byte written into an empty FIFO at edge N is popped at edge N+1. tx_pin falls after edge N+1.
  - START:
    - tx_pin=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA:
    - tx_pin = shift_reg[bit index], LSB first, each bit held CLKS_PER_BIT cycles.
    - After bit 7 (or the parity bit when enabled), go to STOP.
  - STOP:
    - tx_pin=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
  - Never free-runs in IDLE.
- Back-to-back bytes: each frame is followed by exactly one IDLE cycle, so frame period = 10*CLKS_PER_BIT + 1 cycles.
- tx_busy is high from the pop edge through the last STOP cycle.
- wr_data is sampled only on accepted writes. A pop never corrupts a byte being enqueued in the same cycle.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - An even-parity bit (XOR of the 8 data bits) is sent between bit 7 and STOP, held CLKS_PER_BIT cycles.
  - Frame period becomes 11*CLKS_PER_BIT + 1.
- Undefined:
  - No parity logic is compiled; frames are 8N1 exactly as above.

Test Plan (CLK_FREQ=1600000, BAUD_RATE=100000, so CLKS_PER_BIT=16; FIFO_DEPTH=4):
- Reset asserted mid-START of byte 0x5A -> tx_pin=1, tx_busy=0 and fifo_count=0 immediately; no further line activity.
- Single write 0xA5 at edge N -> tx_pin falls after edge N+1, then sends 0 | 1,0,1,0,0,1,0,1 | 1, each level 16 cycles. tx_busy drops after 160 cycles; fifo_empty=1.
- Write 0x01, 0x02, 0x03 on consecutive cycles -> three frames with exactly 1 idle-high cycle between frames. Decoded bytes are 0x01, 0x02, 0x03.
- Fill to fifo_full while the first byte is transmitting, then write 0xFF -> 0xFF is never transmitted and overflow=1. Pulsing clr_overflow clears it next edge; fifo_count is never above 4.
- Write with fifo_count=2 on the same cycle the FSM pops -> fifo_count stays 2, and byte order is preserved on the line.
- With UART_TX_PARITY_EN defined, write 0x07 -> the parity bit is 1 and the frame lasts 176 cycles. Write 0x03 -> the parity bit is 0.
